// File: rtl/hello_world_qsys_poller_pkg.sv
// Shared definitions for the Qsys button poller.
//   poll_state_e : transaction sequencer states of the Avalon-MM read master
//   RUN_CNT_W    : width of the debounce run counter
package hello_world_qsys_poller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    LAT     = 2'd2,
    CAPTURE = 2'd3
  } poll_state_e;

  localparam int RUN_CNT_W = 8;

endpackage

// File: rtl/hello_world_qsys_debounce_filter.sv
// Debounce filter for the polled button sample.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   sample             : current button sample (1 = pressed)
//   sample_strobe      : sample is valid this cycle
//   pressed            : debounced level
//   press_pulse        : one-cycle pulse when pressed rises
//   release_pulse      : one-cycle pulse when pressed falls
module hello_world_qsys_debounce_filter
  import hello_world_qsys_poller_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  input  logic sample_strobe,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(DEBOUNCE_SAMPLES);

  logic                 candidate;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 next_candidate;
  logic [RUN_CNT_W-1:0] next_run;

  // A matching sample extends the run (saturating); a different one starts a
  // new run of length 1 with the new value as candidate.
  always_comb begin
    next_candidate = candidate;
    next_run       = run_cnt;
    if (sample == candidate) begin
      if (run_cnt < RUN_MAX) begin
        next_run = run_cnt + RUN_CNT_W'(1);
      end
    end else begin
      next_candidate = sample;
      next_run       = RUN_CNT_W'(1);
    end
  end

  // The level only moves once a full run agrees and differs from the current
  // level, so the pulse is raised together with the level change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate     <= 1'b0;
      run_cnt       <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sample_strobe) begin
        candidate <= next_candidate;
        run_cnt   <= next_run;
        if ((next_run == RUN_MAX) && (next_candidate != pressed)) begin
          pressed       <= next_candidate;
          press_pulse   <= next_candidate;
          release_pulse <= ~next_candidate;
        end
      end
    end
  end

endmodule

// File: rtl/hello_world_qsys_button_poller.sv
// Avalon-MM master that periodically reads a one-bit PIO data register and
// produces a debounced button level with press/release pulses.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : allows new read transactions to start
//   avm_address      : Avalon address, always the data register (0)
//   avm_read         : Avalon read request
//   avm_waitrequest  : Avalon slave stall
//   avm_readdata     : Avalon read data, only bit 0 is used
//   pressed          : debounced pressed level
//   press_pulse      : one-cycle pulse on press
//   release_pulse    : one-cycle pulse on release
//   sample_strobe    : one-cycle pulse whenever a sample is captured
module hello_world_qsys_button_poller
  import hello_world_qsys_poller_pkg::*;
#(
  parameter int POLL_PERIOD      = 1000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int READ_LATENCY     = 1,
  parameter int ACTIVE_LOW       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        pressed,
  output logic        press_pulse,
  output logic        release_pulse,
  output logic        sample_strobe
);

  localparam int               POLL_W    = $clog2(POLL_PERIOD + 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
  localparam logic [POLL_W-1:0] POLL_MAX  = POLL_W'(POLL_PERIOD);
  localparam logic [1:0]        LAT_LOAD  = 2'(READ_LATENCY - 1);
  localparam logic              INVERT    = (ACTIVE_LOW != 0);

  poll_state_e       state;
  poll_state_e       next_state;
  logic [POLL_W-1:0] poll_cnt;
  logic [1:0]        lat_cnt;
  logic              poll_expired;
  logic              sample;
  logic              unused_readdata;

  // The counter reaches POLL_PERIOD-1 on the POLL_PERIOD-th idle cycle; it may
  // then run on to POLL_PERIOD and hold there while enable is low.
  assign poll_expired    = (poll_cnt >= POLL_LAST);
  assign unused_readdata = ^avm_readdata[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Once a read has been issued it always runs to CAPTURE; enable only gates
  // the start of a new transaction.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (poll_expired && enable) begin
          next_state = READ;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          next_state = (READ_LATENCY <= 1) ? CAPTURE : LAT;
        end
      end
      LAT: begin
        if (lat_cnt <= 2'd1) begin
          next_state = CAPTURE;
        end
      end
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    avm_read      = 1'b0;
    sample_strobe = 1'b0;
    case (state)
      READ:    avm_read      = 1'b1;
      CAPTURE: sample_strobe = 1'b1;
      default: ;
    endcase
  end

  assign avm_address = 2'b00;

  // lat_cnt is reloaded on every READ cycle so a stalled read still leaves
  // with a fresh count; LAT exits when the last latency cycle is reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
      lat_cnt  <= 2'd0;
    end else begin
      if (state == IDLE) begin
        if (poll_cnt < POLL_MAX) begin
          poll_cnt <= poll_cnt + POLL_W'(1);
        end
      end else begin
        poll_cnt <= '0;
      end
      if (state == READ) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == LAT) && (lat_cnt != 2'd0)) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

  assign sample = (state == CAPTURE) ? (avm_readdata[0] ^ INVERT) : 1'b0;

  hello_world_qsys_debounce_filter #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample       (sample),
    .sample_strobe(sample_strobe),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

endmodule

// File: tb/tb_hello_world_qsys_button_poller.sv
// Testbench for hello_world_qsys_button_poller: reactive PIO slave plus a
// history-based debounce reference model.
module tb_hello_world_qsys_button_poller;

  localparam int POLL_PERIOD      = 4;
  localparam int DEBOUNCE_SAMPLES = 3;
  localparam int READ_LATENCY     = 2;
  localparam int ACTIVE_LOW       = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        pressed;
  logic        press_pulse;
  logic        release_pulse;
  logic        sample_strobe;

  always #5 clk = ~clk;

  hello_world_qsys_button_poller #(
    .POLL_PERIOD     (POLL_PERIOD),
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES),
    .READ_LATENCY    (READ_LATENCY),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .pressed        (pressed),
    .press_pulse    (press_pulse),
    .release_pulse  (release_pulse),
    .sample_strobe  (sample_strobe)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic       obs_read, obs_strobe, obs_pressed, obs_press, obs_release;
  logic [1:0] obs_addr;

  bit button_raw = 1'b1;
  bit hist[$];
  bit m_pressed = 1'b0;
  bit exp_pressed = 1'b0;
  bit exp_press = 1'b0;
  bit exp_release = 1'b0;
  bit exp_strobe = 1'b0;
  bit pend_valid = 1'b0;
  bit pend_sample = 1'b0;
  bit lat_active = 1'b0;
  int lat_left = 0;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    hist.delete();
    m_pressed   = 1'b0;
    exp_pressed = 1'b0;
    exp_press   = 1'b0;
    exp_release = 1'b0;
    exp_strobe  = 1'b0;
    pend_valid  = 1'b0;
    lat_active  = 1'b0;
    lat_left    = 0;
  endtask

  // One clock cycle: observe the DUT at the falling edge, advance the
  // reference model, then drive this cycle's inputs and slave data.
  task automatic step(input bit wr, input bit en);
    bit all_same;
    @(negedge clk);
    cyc++;
    obs_read    = avm_read;
    obs_addr    = avm_address;
    obs_strobe  = sample_strobe;
    obs_pressed = pressed;
    obs_press   = press_pulse;
    obs_release = release_pulse;
    exp_press   = 1'b0;
    exp_release = 1'b0;
    if (pend_valid) begin
      pend_valid = 1'b0;
      hist.push_back(pend_sample);
      if (hist.size() > DEBOUNCE_SAMPLES) void'(hist.pop_front());
      if (hist.size() == DEBOUNCE_SAMPLES) begin
        all_same = 1'b1;
        foreach (hist[i]) if (hist[i] != pend_sample) all_same = 1'b0;
        if (all_same && (pend_sample != m_pressed)) begin
          m_pressed   = pend_sample;
          exp_press   = pend_sample;
          exp_release = ~pend_sample;
        end
      end
    end
    exp_pressed     = m_pressed;
    avm_waitrequest = wr;
    enable          = en;
    exp_strobe      = 1'b0;
    avm_readdata    = $urandom();
    if (lat_active) begin
      lat_left--;
      if (lat_left == 0) begin
        lat_active      = 1'b0;
        exp_strobe      = 1'b1;
        avm_readdata[0] = button_raw;
        pend_sample     = (ACTIVE_LOW != 0) ? ~button_raw : button_raw;
        pend_valid      = 1'b1;
      end
    end
    if (reset_n && obs_read && !wr) begin
      lat_active = 1'b1;
      lat_left   = READ_LATENCY;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    model_reset();
    button_raw = 1'b1;
    repeat (3) step(1'b0, 1'b1);
    checks++; if (obs_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_read: got %b want 0", obs_read); end
    checks++; if (obs_addr !== 2'b00) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", obs_addr); end
    checks++; if (obs_pressed !== 1'b0) begin errors++; $display("[TB] FAIL reset_pressed: got %b want 0", obs_pressed); end
    checks++; if (obs_press !== 1'b0) begin errors++; $display("[TB] FAIL reset_press_pulse: got %b want 0", obs_press); end
    checks++; if (obs_release !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_pulse: got %b want 0", obs_release); end
    checks++; if (obs_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b want 0", obs_strobe); end
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic test_poll_period();
    int reads[$];
    int strobes[$];
    int high_cycles = 0;
    bit prev_read = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1);
      if (obs_read) begin
        high_cycles++;
        if (!prev_read) reads.push_back(cyc);
      end
      prev_read = obs_read;
      if (obs_strobe) strobes.push_back(cyc);
      checks++; if (obs_addr !== 2'b00) begin errors++; $display("[TB] FAIL poll_addr: got %0d want 0 at cycle %0d", obs_addr, cyc); end
      checks++; if (obs_strobe !== exp_strobe) begin errors++; $display("[TB] FAIL poll_strobe: got %b want %b at cycle %0d", obs_strobe, exp_strobe, cyc); end
      checks++; if (obs_pressed !== exp_pressed) begin errors++; $display("[TB] FAIL poll_pressed: got %b want %b", obs_pressed, exp_pressed); end
    end
    checks++;
    if (reads.size() < 4) begin
      errors++; $display("[TB] FAIL poll_read_count: got %0d reads want >= 4", reads.size());
    end else begin
      checks++; if (reads[0] - rel_cyc != POLL_PERIOD) begin errors++; $display("[TB] FAIL first_read: got %0d cycles want %0d", reads[0] - rel_cyc, POLL_PERIOD); end
      for (int i = 1; i < reads.size(); i++) begin
        checks++;
        if (reads[i] - reads[i-1] != POLL_PERIOD + READ_LATENCY + 1) begin
          errors++; $display("[TB] FAIL read_spacing: got %0d want %0d", reads[i] - reads[i-1], POLL_PERIOD + READ_LATENCY + 1);
        end
      end
      checks++; if (high_cycles != reads.size()) begin errors++; $display("[TB] FAIL read_width: got %0d high cycles want %0d", high_cycles, reads.size()); end
    end
    checks++;
    if (strobes.size() < 3 || strobes.size() > reads.size()) begin
      errors++; $display("[TB] FAIL strobe_count: got %0d want 3..%0d", strobes.size(), reads.size());
    end else begin
      for (int i = 0; i < strobes.size(); i++) begin
        checks++;
        if (strobes[i] != reads[i] + READ_LATENCY) begin
          errors++; $display("[TB] FAIL capture_latency: got cycle %0d want %0d", strobes[i], reads[i] + READ_LATENCY);
        end
      end
    end
  endtask

  task automatic test_waitrequest();
    for (int iter = 0; iter < 3; iter++) begin
      int n_wait = (iter == 0) ? 3 : int'($urandom_range(1, 5));
      int c0 = -1;
      int held = 1;
      int strobe_at = -1;
      for (int i = 0; i < 30 && c0 < 0; i++) begin
        step(1'b1, 1'b1);
        if (obs_read) c0 = cyc;
      end
      checks++;
      if (c0 < 0) begin
        errors++; $display("[TB] FAIL wait_read_timeout: got no read want read within 30 cycles");
      end else begin
        for (int k = 1; k <= n_wait + READ_LATENCY + 2; k++) begin
          step((k < n_wait) ? 1'b1 : 1'b0, 1'b1);
          if (obs_read) held++;
          if (obs_strobe && strobe_at < 0) strobe_at = cyc;
          checks++; if (obs_strobe !== exp_strobe) begin errors++; $display("[TB] FAIL wait_strobe: got %b want %b at cycle %0d", obs_strobe, exp_strobe, cyc); end
        end
        checks++; if (held != n_wait + 1) begin errors++; $display("[TB] FAIL wait_read_held: got %0d cycles want %0d", held, n_wait + 1); end
        checks++; if (strobe_at != c0 + n_wait + READ_LATENCY) begin errors++; $display("[TB] FAIL wait_capture: got cycle %0d want %0d", strobe_at, c0 + n_wait + READ_LATENCY); end
      end
    end
  endtask

  task automatic test_debounce(input string name, input bit seq[$], input int exp_final, input int exp_np, input int exp_nr);
    int idx = 0;
    int tail = 0;
    int n_press = 0;
    int n_rel = 0;
    for (int k = 0; k < 30 * (seq.size() + 1) && tail < 3; k++) begin
      if (idx < seq.size()) button_raw = seq[idx];
      step(1'b0, 1'b1);
      if (obs_press) n_press++;
      if (obs_release) n_rel++;
      checks++; if (obs_pressed !== exp_pressed) begin errors++; $display("[TB] FAIL %s_pressed: got %b want %b at cycle %0d", name, obs_pressed, exp_pressed, cyc); end
      checks++; if (obs_press !== exp_press) begin errors++; $display("[TB] FAIL %s_press_pulse: got %b want %b at cycle %0d", name, obs_press, exp_press, cyc); end
      checks++; if (obs_release !== exp_release) begin errors++; $display("[TB] FAIL %s_release_pulse: got %b want %b at cycle %0d", name, obs_release, exp_release, cyc); end
      if (idx == seq.size()) tail++;
      if (obs_strobe && idx < seq.size()) idx++;
    end
    checks++; if (idx != seq.size()) begin errors++; $display("[TB] FAIL %s_timeout: got %0d captures want %0d", name, idx, seq.size()); end
    if (exp_final >= 0) begin
      checks++; if (obs_pressed !== exp_final[0]) begin errors++; $display("[TB] FAIL %s_final: got %b want %0d", name, obs_pressed, exp_final); end
    end
    if (exp_np >= 0) begin
      checks++; if (n_press != exp_np) begin errors++; $display("[TB] FAIL %s_press_count: got %0d want %0d", name, n_press, exp_np); end
    end
    if (exp_nr >= 0) begin
      checks++; if (n_rel != exp_nr) begin errors++; $display("[TB] FAIL %s_release_count: got %0d want %0d", name, n_rel, exp_nr); end
    end
  endtask

  task automatic test_enable_lat();
    int c0 = -1;
    int cap = -1;
    int bad_reads = 0;
    int off_len = $urandom_range(POLL_PERIOD + 3, POLL_PERIOD + 10);
    int c_en;
    int rd = -1;
    for (int i = 0; i < 30 && c0 < 0; i++) begin
      step(1'b0, 1'b1);
      if (obs_read) c0 = cyc;
    end
    checks++;
    if (c0 < 0) begin
      errors++; $display("[TB] FAIL en_read_timeout: got no read want read within 30 cycles");
    end else begin
      for (int j = 0; j <= off_len; j++) begin
        step(1'b0, 1'b0);
        if (obs_strobe && cap < 0) cap = cyc;
        if (obs_read) bad_reads++;
      end
      checks++; if (cap != c0 + READ_LATENCY) begin errors++; $display("[TB] FAIL en_capture: got cycle %0d want %0d", cap, c0 + READ_LATENCY); end
      checks++; if (bad_reads != 0) begin errors++; $display("[TB] FAIL en_no_read: got %0d reads want 0", bad_reads); end
      step(1'b0, 1'b1);
      c_en = cyc;
      for (int j = 0; j < 10 && rd < 0; j++) begin
        step(1'b0, 1'b1);
        if (obs_read) rd = cyc;
      end
      checks++; if (rd != c_en + 1) begin errors++; $display("[TB] FAIL en_resume: got read at cycle %0d want %0d", rd, c_en + 1); end
    end
  endtask

  task automatic test_reset_mid_read();
    int c0 = -1;
    int rd = -1;
    int early_strobe = 0;
    for (int i = 0; i < 30 && c0 < 0; i++) begin
      step(1'b1, 1'b1);
      if (obs_read) c0 = cyc;
    end
    checks++;
    if (c0 < 0) begin
      errors++; $display("[TB] FAIL rst_read_timeout: got no read want read within 30 cycles");
    end else begin
      checks++; if (pressed !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_pressed: got %b want 1", pressed); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (avm_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_read: got %b want 0", avm_read); end
      checks++; if (pressed !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_pressed: got %b want 0", pressed); end
      checks++; if (sample_strobe !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_async_pulses: got %b%b%b want 000", sample_strobe, press_pulse, release_pulse);
      end
      model_reset();
      repeat (2) step(1'b0, 1'b1);
      reset_n = 1'b1;
      rel_cyc = cyc;
      for (int j = 0; j < 20 && rd < 0; j++) begin
        step(1'b0, 1'b1);
        if (obs_read) rd = cyc;
        else if (obs_strobe) early_strobe++;
      end
      checks++; if (rd - rel_cyc != POLL_PERIOD) begin errors++; $display("[TB] FAIL rst_restart: got %0d cycles want %0d", rd - rel_cyc, POLL_PERIOD); end
      checks++; if (early_strobe != 0) begin errors++; $display("[TB] FAIL rst_no_resume: got %0d strobes want 0", early_strobe); end
    end
  endtask

  initial begin
    bit s[$];
    $display("[TB] starting");
    test_reset();
    test_poll_period();
    test_waitrequest();
    s = '{1'b1, 1'b0, 1'b0, 1'b0};
    test_debounce("press", s, 1, 1, 0);
    s = '{1'b1, 1'b1, 1'b1};
    test_debounce("release", s, 0, 0, 1);
    s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    test_debounce("bounce", s, 0, 0, 0);
    s.delete();
    for (int r = 0; r < 8; r++) begin
      bit v = 1'(($urandom() & 32'd1));
      int len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) s.push_back(v);
    end
    test_debounce("random", s, -1, -1, -1);
    s = '{1'b0, 1'b0, 1'b0};
    test_debounce("hold", s, 1, -1, -1);
    test_enable_lat();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hello_world_qsys_button_poller.md
# hello_world_qsys_button_poller

Avalon-MM master that periodically reads a single-bit input PIO slave (register 0, fixed read latency) and turns the raw button sample into a debounced level plus one-cycle press/release pulses. It sits between the Qsys fabric and the clock-setting logic, so time-set buttons work without any CPU polling.

## Interface
- POLL_PERIOD, 1000: idle cycles between read transactions (≥1).
- DEBOUNCE_SAMPLES, 4: consecutive identical samples required to change the debounced level (≥1, ≤255).
- READ_LATENCY, 1: fixed slave read latency in cycles after read acceptance (1..3).
- ACTIVE_LOW, 1: 1 = raw bit 0 low means pressed.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = polling allowed; 0 = no new reads start.
- avm_address  out  2  always 0 (data register).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall; read held while high.
- avm_readdata  in  32  slave data; only bit 0 used.
- pressed  out  1  debounced pressed level.
- press_pulse  out  1  one-cycle pulse on pressed 0→1.
- release_pulse  out  1  one-cycle pulse on pressed 1→0.
- sample_strobe  out  1  one-cycle pulse whenever a sample is captured.

## Operation
- States: IDLE, READ, LAT, CAPTURE.
- IDLE: poll counter counts POLL_PERIOD cycles; on expiry with enable=1 → READ. If enable=0 at expiry, stay in IDLE with counter held at expiry until enable=1.
- READ: avm_read=1, avm_address=0. Stays while avm_waitrequest=1. Cycle with avm_waitrequest=0 = acceptance → LAT with latency counter loaded to READ_LATENCY-1 (READ_LATENCY=1 → straight to CAPTURE next cycle).
- LAT: count down; at 0 → CAPTURE.
- CAPTURE: sample = avm_readdata[0] XOR ACTIVE_LOW; sample_strobe=1; → IDLE, poll counter restarts.
- enable deassertion never aborts READ/LAT/CAPTURE; the in-flight transaction completes.
- Debounce: candidate register + run counter. Captured sample equal to candidate → counter increments, saturating at DEBOUNCE_SAMPLES; different → candidate=sample, counter=1. When counter reaches DEBOUNCE_SAMPLES and candidate ≠ pressed, pressed takes candidate and the matching pulse fires.
- Widths: poll counter $clog2(POLL_PERIOD+1); run counter 8 bits.

## Timing
- Reset values: avm_read=0, avm_address=0, pressed=0, press_pulse=0, release_pulse=0, sample_strobe=0; state IDLE, poll counter 0, candidate=0, run counter 0.
- First read asserted POLL_PERIOD cycles after reset release (enable=1).
- Data captured exactly READ_LATENCY cycles after the acceptance cycle.
- pressed and pulse update in the cycle after sample_strobe; pulses last exactly one cycle.
- Read-to-read spacing with zero waitrequest = POLL_PERIOD + READ_LATENCY + 1 cycles.
- DEBOUNCE_SAMPLES=1: every captured change is reflected immediately.
- Reset asserted mid-READ drops avm_read asynchronously; no partial transaction resumes.
- avm_readdata ignored outside CAPTURE; bits 31:1 ignored always.

## Structure
- Package hello_world_qsys_poller_pkg: state enum (IDLE, READ, LAT, CAPTURE), run counter width constant.
- Sub-module hello_world_qsys_debounce_filter: candidate/run counter/pressed/pulses, driven by sample and sample_strobe; top holds FSM and Avalon master signals.

## Test plan
- POLL_PERIOD=4, READ_LATENCY=1, waitrequest=0: avm_read high 1 cycle every 6 cycles; first read at cycle 4 after reset release; avm_address=0.
- waitrequest high 3 cycles during READ: avm_read held 4 cycles; capture 1 cycle after the cycle waitrequest falls.
- DEBOUNCE_SAMPLES=3, ACTIVE_LOW=1, readdata bit0 = 1,0,0,0: pressed rises after the third 0 sample with a single press_pulse; then 1,1,1 → release_pulse once, pressed=0.
- Bouncing 0,1,0,1,0 with DEBOUNCE_SAMPLES=3: pressed stays 0, no pulses.
- enable dropped during LAT: capture still occurs; no new read until enable=1, then read next cycle.
- reset_n low during READ: avm_read=0 immediately, all outputs at reset values; polling restarts POLL_PERIOD cycles after release.
